// File: rtl/cont_nbits_updown_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// direction encoding and width helpers for the prescaler phase register.
package cont_nbits_updown_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  function automatic int cont_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Phase register needs at least one bit even when PRESCALE is a power of two of 1 or 2.
  function automatic int cont_pc_width(input int prescale);
    int w;
    w = cont_clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cont_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles; restart
// forces the phase back to zero. PRESCALE = 1 degenerates to a gated wire.
module cont_prescaler
  import cont_nbits_updown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ restart;
    assign tick = enable & reset_n;
  end else begin : g_count
    localparam int PCW = cont_pc_width(PRESCALE);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;

    always_comb begin
      pc_d = pc_q;
      if (restart) begin
        pc_d = '0;
      end else if (enable) begin
        pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pc_q <= '0;
      end else begin
        pc_q <= pc_d;
      end
    end

    // Gating with reset_n keeps tick low while reset is held, even with enable high.
    assign tick = enable & reset_n & (pc_q == PC_LAST);
  end

endmodule

// File: rtl/cont_nbits_updown.sv
// Modulo-N up/down counter with clear, clamped load, prescaled enable and a
// combinational cascade terminal count.
module cont_nbits_updown
  import cont_nbits_updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             tick
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] load_val;
  logic             tick_w;
  logic             restart;

  assign restart = clear | load;

  cont_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .restart(restart),
    .tick   (tick_w)
  );

  // A full-range modulus can never see an out-of-range din, so no clamp is built.
  if (MODULO == (1 << WIDTH)) begin : g_noclamp
    assign load_val = din;
  end else begin : g_clamp
    assign load_val = (din > Q_MAX) ? Q_MAX : din;
  end

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (tick_w) begin
      if (up_down == CNT_UP) begin
        q_d = (q_q == Q_MAX) ? '0 : q_q + 1'b1;
      end else begin
        q_d = (q_q == '0) ? Q_MAX : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign tick = tick_w;
  assign TC   = tick_w & ((up_down == CNT_UP) ? (q_q == Q_MAX) : (q_q == '0));

endmodule

// File: tb/tb_cont_nbits_updown.sv
// Directed bench: BCD counter, prescaled counter and a two-digit BCD cascade.
module tb_cont_nbits_updown;
  import cont_nbits_updown_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // BCD instance: WIDTH 4, MODULO 10, PRESCALE 1
  logic       en_b = 0, ud_b = 0, clr_b = 0, ld_b = 0;
  logic [3:0] din_b = '0;
  logic [3:0] q_b;
  logic       tc_b, tick_b;

  // Prescaled instance: WIDTH 4, MODULO 16, PRESCALE 3
  logic       en_p = 0, ud_p = 1, clr_p = 0, ld_p = 0;
  logic [3:0] din_p = '0;
  logic [3:0] q_p;
  logic       tc_p, tick_p;

  // Cascade: two BCD digits, digit 1 enabled by digit 0's TC
  logic       en_c = 0, ud_c = 1;
  logic [3:0] din_c = '0;
  logic [3:0] q_c0, q_c1;
  logic       tc_c0, tc_c1, tick_c0, tick_c1;

  int checks = 0;
  int failures = 0;

  cont_nbits_updown #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_bcd (
    .clk(clk), .reset_n(rst_n), .enable(en_b), .up_down(ud_b), .clear(clr_b),
    .load(ld_b), .din(din_b), .Q(q_b), .TC(tc_b), .tick(tick_b));

  cont_nbits_updown #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) u_pre (
    .clk(clk), .reset_n(rst_n), .enable(en_p), .up_down(ud_p), .clear(clr_p),
    .load(ld_p), .din(din_p), .Q(q_p), .TC(tc_p), .tick(tick_p));

  cont_nbits_updown #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_c0 (
    .clk(clk), .reset_n(rst_n), .enable(en_c), .up_down(ud_c), .clear(1'b0),
    .load(1'b0), .din(din_c), .Q(q_c0), .TC(tc_c0), .tick(tick_c0));

  cont_nbits_updown #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_c1 (
    .clk(clk), .reset_n(rst_n), .enable(tc_c0), .up_down(ud_c), .clear(1'b0),
    .load(1'b0), .din(din_c), .Q(q_c1), .TC(tc_c1), .tick(tick_c1));

  task automatic check_val(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with enable high and counting down
    en_b = 1; ud_b = CNT_DOWN;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_q", int'(q_b), 0);
      check_val("rst_tc", int'(tc_b), 0);
      check_val("rst_tick", int'(tick_b), 0);
    end
    rst_n = 1;
    #1;
    check_val("rel_tc_before_wrap", int'(tc_b), 1);
    step();
    check_val("rel_down_wrap_q", int'(q_b), 9);
    check_val("rel_tc_after_wrap", int'(tc_b), 0);

    // BCD up count from zero
    ud_b = CNT_UP; clr_b = 1;
    step();
    clr_b = 0;
    check_val("clr_q", int'(q_b), 0);
    for (int i = 0; i < 20; i++) begin
      check_val("bcd_q", int'(q_b), i % 10);
      check_val("bcd_tc", int'(tc_b), (i % 10 == 9) ? 1 : 0);
      if (i < 19) step();
    end
    en_b = 0;
    #1;
    check_val("bcd_tc_drop", int'(tc_b), 0);
    step();
    check_val("bcd_hold", int'(q_b), 9);

    // Load, clamp and priority
    ld_b = 1; din_b = 4'd7;
    step();
    check_val("load_7", int'(q_b), 7);
    din_b = 4'd13;
    step();
    check_val("load_clamp", int'(q_b), 9);
    clr_b = 1; din_b = 4'd4;
    step();
    check_val("clear_over_load", int'(q_b), 0);
    clr_b = 0; en_b = 1; din_b = 4'd3;
    #1;
    check_val("load_tick_tickhigh", int'(tick_b), 1);
    step();
    check_val("load_over_tick", int'(q_b), 3);
    ld_b = 0;
    step();
    check_val("up_after_load", int'(q_b), 4);
    ud_b = CNT_DOWN;
    step();
    check_val("dir_change", int'(q_b), 3);
    en_b = 0;

    // Prescaler: tick every third enabled cycle
    en_p = 1;
    for (int k = 0; k < 9; k++) begin
      check_val("pre_tick", int'(tick_p), (k % 3 == 2) ? 1 : 0);
      check_val("pre_q", int'(q_p), k / 3);
      step();
    end
    check_val("pre_q_after9", int'(q_p), 3);
    step();
    en_p = 0;
    #1;
    check_val("pre_gap_tick", int'(tick_p), 0);
    step();
    step();
    check_val("pre_gap_hold", int'(q_p), 3);
    en_p = 1;
    #1;
    check_val("pre_phase1_tick", int'(tick_p), 0);
    step();
    check_val("pre_phase2_tick", int'(tick_p), 1);
    step();
    check_val("pre_q_resume", int'(q_p), 4);
    step();
    ld_p = 1; din_p = 4'd10;
    step();
    ld_p = 0;
    check_val("pre_load_q", int'(q_p), 10);
    check_val("pre_after_load_t0", int'(tick_p), 0);
    step();
    check_val("pre_after_load_t1", int'(tick_p), 0);
    step();
    check_val("pre_after_load_t2", int'(tick_p), 1);
    step();
    check_val("pre_load_step", int'(q_p), 11);
    en_p = 0;

    // Two-digit cascade
    en_c = 1; ud_c = CNT_UP;
    for (int i = 0; i < 45; i++) step();
    check_val("cas45_q1", int'(q_c1), 4);
    check_val("cas45_q0", int'(q_c0), 5);
    for (int i = 0; i < 54; i++) step();
    check_val("cas99_q1", int'(q_c1), 9);
    check_val("cas99_q0", int'(q_c0), 9);
    check_val("cas99_tc0", int'(tc_c0), 1);
    check_val("cas99_tc1", int'(tc_c1), 1);
    step();
    check_val("cas_wrap_q1", int'(q_c1), 0);
    check_val("cas_wrap_q0", int'(q_c0), 0);
    ud_c = CNT_DOWN;
    #1;
    check_val("cas_dn_tc1", int'(tc_c1), 1);
    step();
    check_val("cas_dn_q1", int'(q_c1), 9);
    check_val("cas_dn_q0", int'(q_c0), 9);
    en_c = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
